fifo_sync_flags: RTL and testbench
==================================

// Module: fifo_sync_flags
// PURPOSE
// - Next-generation single-clock FIFO with First Word Fall Through (FWFT) reads.
// - Adds over the current buffer: any FIFO_DEPTH >= 2 (not only powers of two), an occupancy count,
//   programmable almost-full/almost-empty flags, write-while-full, flush, and sticky overflow/underflow flags.
// - Sits between producer/consumer pipelines where backpressure needs early warning.
// PARAMETERS
// - DATA_WIDTH  32      word width in bits
// - FIFO_DEPTH  32      number of stored words; legal range >= 2, any integer
// - AF_THRESH   30      almost_full_o asserts when count >= AF_THRESH; legal range 1..FIFO_DEPTH
// - AE_THRESH   2       almost_empty_o asserts when count <= AE_THRESH; legal range 0..FIFO_DEPTH-1
// - CW = $clog2(FIFO_DEPTH+1) is a localparam (count width)
// PORTS
// - clk_i           in   1           single clock, all logic on posedge
// - rst_i           in   1           synchronous reset, active-high
// - flush_i         in   1           synchronous empty, active-high
// - wr_en_i         in   1           write request
// - wr_data_i       in   DATA_WIDTH  write data
// - rd_en_i         in   1           read request; pops the current head
// - rd_data_o       out  DATA_WIDTH  FWFT head word
// - full_o          out  1           count == FIFO_DEPTH
// - empty_o         out  1           count == 0
// - almost_full_o   out  1           count >= AF_THRESH
// - almost_empty_o  out  1           count <= AE_THRESH
// - count_o         out  CW          words stored, 0..FIFO_DEPTH
// - err_clr_i       in   1           clears the sticky error flags
// - overflow_o      out  1           sticky: a write was dropped
// - underflow_o     out  1           sticky: a read was made while empty
// BEHAVIOUR
// - Reset (rst_i=1 at posedge) sets: pointers=0, count_o=0, empty_o=1, full_o=0,
//   almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0. Memory is not reset.
// - rd_data_o is don't-care while empty_o=1.
// - Priority order at each posedge: rst_i > flush_i > read/write.
// - flush_i: pointers=0, count=0, flags recompute as at reset. Memory and sticky errors are kept.
//   Reads and writes in the same cycle are ignored and do not set any error flag.
// - rd_ok = rd_en_i & !empty_o.
// - wr_ok = wr_en_i & (!full_o | rd_ok): write while full is accepted when a read happens in the same cycle.
// - Pointer wrap: a pointer at FIFO_DEPTH-1 goes to 0; otherwise it increments by 1.
// - Count update: count += wr_ok - rd_ok.
// - All status outputs are registered from the next count. They are valid the cycle after the edge; no combinational path from inputs.
// - FWFT: rd_data_o = mem[rd_ptr], read combinationally.
//   A word written at edge N is on rd_data_o after edge N when the FIFO was empty (1-cycle latency).
//   rd_ok at edge N shows the next word after edge N.
// - Simultaneous read and write with 0 < count < DEPTH: count unchanged, both pointers advance.
// - overflow_o sets on wr_en_i & full_o & !rd_ok. underflow_o sets on rd_en_i & empty_o (see macro).
//   err_clr_i clears both; a set in the same cycle wins over the clear.
// CONFIGURATION
// - Macro FIFO_SYNC_BYPASS_EN.
// - Defined: when empty_o=1 and wr_en_i=1, rd_data_o = wr_data_i combinationally.
//   In that state, rd_en_i & wr_en_i consumes the word directly: count stays 0, no pointer moves,
//   no underflow is flagged. Adds the wr_data_i->rd_data_o path to the critical path.
// - Undefined: no bypass. Reading while empty is always an underflow and does not pop.
// TESTING
// - Reset, then write 1..32 (DEPTH=32) -> full_o=1, count_o=32, almost_full_o from count 30, no overflow.
// - At full, write + read together -> count stays 32, head advances 1->2, overflow_o stays 0.
//   Then write alone -> overflow_o=1, count 32.
// - DEPTH=5: 12 write/read pairs with data A0..AB -> rd_data_o order A0..AB.
//   Pointers wrap 4->0, empty_o=1 at the end.
// - Read while empty (no bypass) -> underflow_o=1 and stays high until err_clr_i; count stays 0.
// - With count=7, assert flush_i together with wr_en_i -> count_o=0, empty_o=1, almost_empty_o=1;
//   the write is dropped and overflow_o is unchanged.
// - FIFO_SYNC_BYPASS_EN: empty, wr_data_i=0xDEAD with rd_en_i=1 -> rd_data_o=0xDEAD in the same cycle,
//   count stays 0, underflow_o=0.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// Single-clock FWFT FIFO for any depth >= 2 with occupancy count, almost-full/empty and sticky error flags.
// Define FIFO_SYNC_BYPASS_EN to let a write into an empty FIFO feed rd_data_o (and a same-cycle read) directly.
module fifo_sync_flags #(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 32,
  parameter  int AF_THRESH  = 30,
  parameter  int AE_THRESH  = 2,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CW-1:0]         count_o,
  input  logic                  err_clr_i,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full, r_empty, r_af, r_ae, r_ovf, r_unf;

  logic                  w_bypass, w_rd_ok, w_wr_ok, w_ovf_set, w_unf_set;
  logic [CW-1:0]         w_count_nxt;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_bypass = 1'b0;
`ifdef FIFO_SYNC_BYPASS_EN
    w_bypass = r_empty & wr_en_i & rd_en_i;
`endif
    w_rd_ok     = rd_en_i & ~r_empty & ~flush_i;
    w_wr_ok     = wr_en_i & (~r_full | w_rd_ok) & ~flush_i & ~w_bypass;
    w_ovf_set   = wr_en_i & r_full & ~w_rd_ok & ~flush_i;
    w_unf_set   = rd_en_i & r_empty & ~w_bypass & ~flush_i;
    w_count_nxt = flush_i ? '0 : r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_rd_ok) r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= CW'(AF_THRESH));
      r_ae    <= (w_count_nxt <= CW'(AE_THRESH));
      // A set in the same cycle overrides the clear.
      r_ovf   <= w_ovf_set | (r_ovf & ~err_clr_i);
      r_unf   <= w_unf_set | (r_unf & ~err_clr_i);
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which words are valid.
  always_ff @(posedge clk_i) begin
    if (w_wr_ok && !rst_i) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_comb begin
    rd_data_o = r_mem[r_rd_ptr];
`ifdef FIFO_SYNC_BYPASS_EN
    if (r_empty && wr_en_i) rd_data_o = wr_data_i;
`endif
  end

  assign count_o        = r_count;
  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_af;
  assign almost_empty_o = r_ae;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_unf;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Scoreboard bench: a 32-deep and a 5-deep FIFO share stimulus; a queue-based model predicts each.
// Honours FIFO_SYNC_BYPASS_EN in the same way as the design.
module tb_fifo_sync_flags;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, wr_en_i, rd_en_i, err_clr_i;
  logic [31:0] wr_data_i;

  logic [31:0] d0_rd_data, d1_rd_data;
  logic [5:0]  d0_count;
  logic [2:0]  d1_count;
  logic        d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic        d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;

  always #5 clk_i = ~clk_i;

  fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(32), .AF_THRESH(30), .AE_THRESH(2)) u_d0 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_data_o(d0_rd_data), .full_o(d0_full), .empty_o(d0_empty),
    .almost_full_o(d0_af), .almost_empty_o(d0_ae), .count_o(d0_count), .err_clr_i(err_clr_i),
    .overflow_o(d0_ovf), .underflow_o(d0_unf));

  fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_d1 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_data_o(d1_rd_data), .full_o(d1_full), .empty_o(d1_empty),
    .almost_full_o(d1_af), .almost_empty_o(d1_ae), .count_o(d1_count), .err_clr_i(err_clr_i),
    .overflow_o(d1_ovf), .underflow_o(d1_unf));

  typedef struct {
    int          inst;
    int          cnt;
    bit          full, empty, af, ae, ovf, unf, has_head;
    logic [31:0] head;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[2][$];
  bit          m_ovf[2], m_unf[2];
  int          dep[2] = '{32, 5};
  int          afth[2] = '{30, 4};
  int          aeth[2] = '{2, 1};
  int          n_chk = 0;
  int          n_err = 0;
  bit          byp_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit rst, input bit fl, input bit wr,
                            input logic [31:0] wd, input bit rd, input bit clr);
    exp_t e;
    bit   empty, full, byp, rd_ok, wr_ok;
    if (rst) begin
      mq[i].delete();
      m_ovf[i] = 0;
      m_unf[i] = 0;
    end else if (fl) begin
      mq[i].delete();
      if (clr) begin m_ovf[i] = 0; m_unf[i] = 0; end
    end else begin
      empty = (mq[i].size() == 0);
      full  = (mq[i].size() == dep[i]);
      byp   = byp_en && empty && wr && rd;
      rd_ok = rd && !empty;
      wr_ok = wr && (!full || rd_ok) && !byp;
      if (clr) begin m_ovf[i] = 0; m_unf[i] = 0; end
      if (wr && full && !rd_ok) m_ovf[i] = 1;
      if (rd && empty && !byp)  m_unf[i] = 1;
      if (rd_ok) void'(mq[i].pop_front());
      if (wr_ok) mq[i].push_back(wd);
    end
    e.inst     = i;
    e.cnt      = mq[i].size();
    e.full     = (e.cnt == dep[i]);
    e.empty    = (e.cnt == 0);
    e.af       = (e.cnt >= afth[i]);
    e.ae       = (e.cnt <= aeth[i]);
    e.ovf      = m_ovf[i];
    e.unf      = m_unf[i];
    e.has_head = (e.cnt > 0);
    e.head     = e.has_head ? mq[i][0] : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit fl, input bit wr, input logic [31:0] wd,
                     input bit rd, input bit clr);
    rst_i = rst; flush_i = fl; wr_en_i = wr; wr_data_i = wd; rd_en_i = rd; err_clr_i = clr;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, rst, fl, wr, wd, rd, clr);
    rst_i = 0; flush_i = 0; wr_en_i = 0; rd_en_i = 0; err_clr_i = 0;
  endtask

  // Monitor: compares every predicted post-edge state on the following falling edge.
  initial begin
    exp_t        e;
    logic [31:0] a_cnt, a_head;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    forever begin
      @(negedge clk_i);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.inst == 0) begin
          a_cnt = 32'(d0_count); a_head = d0_rd_data; a_full = d0_full; a_empty = d0_empty;
          a_af = d0_af; a_ae = d0_ae; a_ovf = d0_ovf; a_unf = d0_unf;
        end else begin
          a_cnt = 32'(d1_count); a_head = d1_rd_data; a_full = d1_full; a_empty = d1_empty;
          a_af = d1_af; a_ae = d1_ae; a_ovf = d1_ovf; a_unf = d1_unf;
        end
        check($sformatf("d%0d count", e.inst), a_cnt, e.cnt);
        check($sformatf("d%0d full", e.inst), a_full, e.full);
        check($sformatf("d%0d empty", e.inst), a_empty, e.empty);
        check($sformatf("d%0d almost_full", e.inst), a_af, e.af);
        check($sformatf("d%0d almost_empty", e.inst), a_ae, e.ae);
        check($sformatf("d%0d overflow", e.inst), a_ovf, e.ovf);
        check($sformatf("d%0d underflow", e.inst), a_unf, e.unf);
        if (e.has_head) check($sformatf("d%0d rd_data", e.inst), a_head, e.head);
      end
    end
  end

  initial begin
    int wp, rp;
    byp_en = 1'b0;
`ifdef FIFO_SYNC_BYPASS_EN
    byp_en = 1'b1;
`endif
    rst_i = 1; flush_i = 0; wr_en_i = 0; wr_data_i = 0; rd_en_i = 0; err_clr_i = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Fill to 32; the 5-deep copy overflows along the way.
    for (int k = 1; k <= 32; k++) cyc(0, 0, 1, 32'(k), 0, 0);
    cyc(0, 0, 1, 32'd33, 1, 0);   // write+read at full
    cyc(0, 0, 1, 32'd34, 0, 0);   // write alone at full -> overflow
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);        // clear errors
    cyc(0, 1, 0, 0, 0, 0);        // flush

    // Write/read pairs A0..AB through the 5-deep FIFO, wrapping its pointers.
    cyc(0, 0, 1, 32'hA0, 0, 0);
    for (int k = 1; k < 12; k++) cyc(0, 0, 1, 32'hA0 + 32'(k), 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // Read while empty -> sticky underflow until cleared.
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Count 7 then flush with write and read: write dropped, no error set.
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 32'h700 + 32'(k), 0, 0);
    cyc(0, 1, 1, 32'h7FF, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);

`ifdef FIFO_SYNC_BYPASS_EN
    // Bypass: empty FIFO, write+read of 0xDEAD seen combinationally, nothing stored.
    wr_en_i = 1; rd_en_i = 1; wr_data_i = 32'hDEAD;
    #1;
    check("d0 bypass rd_data", d0_rd_data, 32'hDEAD);
    check("d1 bypass rd_data", d1_rd_data, 32'hDEAD);
    cyc(0, 0, 1, 32'hDEAD, 1, 0);
`endif

    // Randomised phases alternating fill-biased and drain-biased traffic.
    for (int p = 0; p < 4; p++) begin
      wp = (p % 2 == 0) ? 75 : 30;
      rp = (p % 2 == 0) ? 30 : 75;
      for (int k = 0; k < 150; k++)
        cyc(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < wp), $urandom,
            ($urandom_range(0, 99) < rp), ($urandom_range(0, 15) == 0));
    end

    @(negedge clk_i);
    @(negedge clk_i);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
